ppu_pkt_ingress: RTL

PPU_PKT_INGRESS -- requirements
Module: ppu_pkt_ingress

---
 rtl/ppu_pkt_ingress_pkg.sv | 14 +
 rtl/ppu_pkt_ram.sv | 21 ++
 rtl/ppu_pkt_ingress.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/ppu_pkt_ingress_pkg.sv
// Shared widths and FSM encoding for the packet ingress buffer.
package ppu_pkt_ingress_pkg;
    localparam int DATA_W  = 64;
    localparam int ROUTE_W = 24;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RX       = 3'd1,
        ST_CLOSE    = 3'd2,
        ST_PREFETCH = 3'd3,
        ST_HOLD     = 3'd4,
        ST_RELEASE  = 3'd5
    } state_t;
endpackage

// File: rtl/ppu_pkt_ram.sv
// Simple dual-port packet buffer: one write port, one registered read port.
module ppu_pkt_ram
    import ppu_pkt_ingress_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/ppu_pkt_ingress.sv
// Receives one packet from the classifier into a buffer, then streams it to the core
// at one word per cycle with latched tags, length and truncation status.
module ppu_pkt_ingress
    import ppu_pkt_ingress_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_req,
    output logic               in_ack,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_wr,
    input  logic [ROUTE_W-1:0] in_pkt_route,
    input  logic               in_bypass,
    input  logic               in_protocol,
    output logic               pkt_valid,
    input  logic               pkt_rd_en,
    output logic [DATA_W-1:0]  pkt_data,
    output logic               pkt_last,
    output logic [ROUTE_W-1:0] pkt_route,
    output logic               pkt_bypass,
    output logic               pkt_protocol,
    output logic [ADDR_W:0]    pkt_len,
    output logic               pkt_trunc,
    output logic [15:0]        drop_count,
    output state_t             dbg_state
);
    localparam logic [ADDR_W:0] DEPTH   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] LEN_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [1:0]        rst_sync;
    logic              rst_n;
    state_t            state, state_nxt;
    logic [ADDR_W:0]   wr_ptr, rd_ptr;
    logic              ram_we, ram_re, pop;
    logic [ADDR_W-1:0] ram_raddr;
    logic [DATA_W-1:0] ram_rdata;

    // Assertion is immediate; release is held off two clock edges.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    assign in_ack    = (state == ST_RX);
    assign pkt_valid = (state == ST_HOLD);
    assign pkt_last  = (state == ST_HOLD) && (rd_ptr == pkt_len - LEN_ONE);
    assign dbg_state = state;

    // In HOLD the RAM output always carries the word after pkt_data, so a pop can
    // refill pkt_data immediately while the RAM fetches one further ahead.
    always_comb begin
        state_nxt = state;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_raddr = '0;
        pop       = 1'b0;
        case (state)
            ST_IDLE: if (in_req) state_nxt = ST_RX;
            ST_RX: begin
                if (!in_req) state_nxt = ST_CLOSE;
                else         ram_we = in_wr && (wr_ptr != DEPTH);
            end
            ST_CLOSE: begin
                if (pkt_len == '0) begin
                    state_nxt = ST_IDLE;
                end else begin
                    ram_re    = 1'b1;
                    state_nxt = ST_PREFETCH;
                end
            end
            ST_PREFETCH: begin
                ram_re    = 1'b1;
                ram_raddr = ADDR_W'(1);
                state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                pop       = pkt_rd_en;
                ram_re    = 1'b1;
                ram_raddr = rd_ptr[ADDR_W-1:0] + (pop ? ADDR_W'(2) : ADDR_W'(1));
                if (pop && pkt_last) state_nxt = ST_RELEASE;
            end
            ST_RELEASE: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            pkt_data     <= '0;
            pkt_route    <= '0;
            pkt_bypass   <= 1'b0;
            pkt_protocol <= 1'b0;
            pkt_len      <= '0;
            pkt_trunc    <= 1'b0;
            drop_count   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (in_req) begin
                        wr_ptr    <= '0;
                        pkt_trunc <= 1'b0;
                    end
                end
                ST_RX: begin
                    if (!in_req) begin
                        pkt_len <= wr_ptr;
                    end else if (in_wr) begin
                        if (wr_ptr == DEPTH) pkt_trunc <= 1'b1;
                        else                 wr_ptr <= wr_ptr + LEN_ONE;
                        if (wr_ptr == '0) begin
                            pkt_route    <= in_pkt_route;
                            pkt_bypass   <= in_bypass;
                            pkt_protocol <= in_protocol;
                        end
                    end
                end
                ST_CLOSE: begin
                    rd_ptr <= '0;
                    if (pkt_len == '0 && drop_count != 16'hFFFF)
                        drop_count <= drop_count + 16'd1;
                end
                ST_PREFETCH: pkt_data <= ram_rdata;
                ST_HOLD: begin
                    if (pop && !pkt_last) begin
                        pkt_data <= ram_rdata;
                        rd_ptr   <= rd_ptr + LEN_ONE;
                    end
                end
                ST_RELEASE: begin
                    if (pkt_trunc && drop_count != 16'hFFFF)
                        drop_count <= drop_count + 16'd1;
                end
                default: ;
            endcase
        end
    end

    ppu_pkt_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr[ADDR_W-1:0]),
        .wdata (in_data),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );
endmodule
